// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
// Covers FSM states, bus size codes, owner encoding and the timeout NOP.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StBusyF = 2'd1,
      StBusyD = 2'd2,
      StResp  = 2'd3
   } arb_state_t;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam logic OWN_FETCH = 1'b0;
   localparam logic OWN_DATA  = 1'b1;

   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

   // The reserved size code 11 is issued on the bus as a word access.
   function automatic logic [1:0] norm_size(input logic [1:0] size);
      return (size == 2'b11) ? SIZE_WORD : size;
   endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Bus watchdog: counts cycles while enabled and flags expiry in the
// TIMEOUT_CYCLES-th counted cycle; cleared at every grant.
module mem_arb_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  clear,
   input  logic                                  count_en,
   output logic                                  expired,
   output logic [$clog2(TIMEOUT_CYCLES+1)-1:0]   count
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] cnt_q;

   // Count is zero in the first busy cycle, so expiry lands on cycle TIMEOUT_CYCLES.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (count_en && (cnt_q != CntLast)) begin
         cnt_q <= cnt_q + CntW'(1);
      end
   end

   assign expired = count_en && (cnt_q == CntLast);
   assign count   = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one request/ack memory port between instruction fetch and load/store,
// data first with a fetch starvation guard and a watchdog on every access.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned FETCH_STARVE_MAX = 4,
   parameter int unsigned TIMEOUT_CYCLES   = 1023,
   parameter logic [31:0] NOP_INSTR        = NOP_INSTR_DEF
) (
   input  logic        CLK_CPU,
   input  logic        resetn,
   input  logic        fetch_enable,
   input  logic [31:0] fetch_addr,
   output logic [31:0] instr_fetch,
   output logic        fetch_valid,
   input  logic        data_en,
   input  logic        data_we,
   input  logic [1:0]  store_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] write_data,
   output logic [31:0] mem_read_data,
   output logic        read_data_valid,
   output logic        write_ready,
   output logic        bus_req,
   output logic        bus_we,
   output logic [1:0]  bus_size,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        timeout_err,
   output logic [31:0] debug
);

   localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [3:0]  StarveMax = 4'(FETCH_STARVE_MAX);

   arb_state_t  state_q, state_d;
   logic        owner_q, owner_d;
   logic [3:0]  starve_q, starve_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] ldata_q, ldata_d;
   logic        err_q, err_d;

   logic           grant_data, grant_fetch, busy;
   logic           wd_expired;
   logic [WdW-1:0] wd_count;

   assign busy = (state_q == StBusyF) || (state_q == StBusyD);

   mem_arb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk      (CLK_CPU),
      .rst_n    (resetn),
      .clear    (grant_data | grant_fetch),
      .count_en (busy),
      .expired  (wd_expired),
      .count    (wd_count)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      starve_d    = starve_q;
      we_d        = we_q;
      size_d      = size_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      instr_d     = instr_q;
      ldata_d     = ldata_q;
      err_d       = err_q;
      grant_data  = 1'b0;
      grant_fetch = 1'b0;

      unique case (state_q)
         StIdle: begin
            grant_data  = data_en && !(fetch_enable && (starve_q == StarveMax));
            grant_fetch = !grant_data && fetch_enable;
            if (!fetch_enable) begin
               starve_d = '0;
            end
            if (grant_data) begin
               state_d = StBusyD;
               owner_d = OWN_DATA;
               we_d    = data_we;
               size_d  = norm_size(store_size);
               addr_d  = data_addr;
               wdata_d = write_data;
               if (fetch_enable && (starve_q != StarveMax)) begin
                  starve_d = starve_q + 4'd1;
               end
            end else if (grant_fetch) begin
               state_d  = StBusyF;
               owner_d  = OWN_FETCH;
               we_d     = 1'b0;
               size_d   = SIZE_WORD;
               addr_d   = fetch_addr;
               wdata_d  = '0;
               starve_d = '0;
            end
         end
         StBusyF, StBusyD: begin
            // A late ack still beats a same-cycle watchdog expiry.
            if (bus_ack) begin
               state_d = StResp;
               if (state_q == StBusyF) begin
                  instr_d = bus_rdata;
               end else if (!we_q) begin
                  ldata_d = bus_rdata;
               end
            end else if (wd_expired) begin
               state_d = StResp;
               err_d   = 1'b1;
               if (state_q == StBusyF) begin
                  instr_d = NOP_INSTR;
               end else if (!we_q) begin
                  ldata_d = '0;
               end
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge CLK_CPU or negedge resetn) begin
      if (!resetn) begin
         state_q  <= StIdle;
         owner_q  <= OWN_FETCH;
         starve_q <= '0;
         we_q     <= 1'b0;
         size_q   <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         instr_q  <= '0;
         ldata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         starve_q <= starve_d;
         we_q     <= we_d;
         size_q   <= size_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         instr_q  <= instr_d;
         ldata_q  <= ldata_d;
         err_q    <= err_d;
      end
   end

   assign bus_req   = busy;
   assign bus_we    = busy && we_q;
   assign bus_size  = size_q;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;

   assign fetch_valid     = (state_q == StResp) && (owner_q == OWN_FETCH);
   assign read_data_valid = (state_q == StResp) && (owner_q == OWN_DATA) && !we_q;
   assign write_ready     = (state_q == StResp) && (owner_q == OWN_DATA) && we_q;

   assign instr_fetch   = instr_q;
   assign mem_read_data = ldata_q;
   assign timeout_err   = err_q;
   assign debug         = {state_q, owner_q, 1'b0, starve_q, 24'(wd_count)};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: requester/responder agents with a
// transaction-level reference model, directed scenarios then random traffic.
module tb_mem_port_arbiter;

   localparam int          STARVE_MAX = 4;
   localparam int          TMO        = 1023;
   localparam logic [31:0] NOP        = 32'h0000_0013;

   logic        CLK_CPU = 1'b0;
   logic        resetn  = 1'b0;
   logic        fetch_enable = 1'b0;
   logic [31:0] fetch_addr = '0;
   logic [31:0] instr_fetch;
   logic        fetch_valid;
   logic        data_en = 1'b0;
   logic        data_we = 1'b0;
   logic [1:0]  store_size = '0;
   logic [31:0] data_addr = '0;
   logic [31:0] write_data = '0;
   logic [31:0] mem_read_data;
   logic        read_data_valid;
   logic        write_ready;
   logic        bus_req;
   logic        bus_we;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = '0;
   logic        timeout_err;
   logic [31:0] debug;

   mem_port_arbiter dut (
      .CLK_CPU         (CLK_CPU),
      .resetn          (resetn),
      .fetch_enable    (fetch_enable),
      .fetch_addr      (fetch_addr),
      .instr_fetch     (instr_fetch),
      .fetch_valid     (fetch_valid),
      .data_en         (data_en),
      .data_we         (data_we),
      .store_size      (store_size),
      .data_addr       (data_addr),
      .write_data      (write_data),
      .mem_read_data   (mem_read_data),
      .read_data_valid (read_data_valid),
      .write_ready     (write_ready),
      .bus_req         (bus_req),
      .bus_we          (bus_we),
      .bus_size        (bus_size),
      .bus_addr        (bus_addr),
      .bus_wdata       (bus_wdata),
      .bus_ack         (bus_ack),
      .bus_rdata       (bus_rdata),
      .timeout_err     (timeout_err),
      .debug           (debug)
   );

   always #5 CLK_CPU = ~CLK_CPU;

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dreq_t;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'h0050_0093;
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   // Agents and responder controls
   logic [31:0] fetch_q[$];
   dreq_t       data_q[$];
   int          fetch_gap = 0, data_gap = 0, gap_max = 0;
   int          fixed_delay = -1, cur_delay = 0, ack_wait = 0;
   bit          hang_next = 0, cur_hang = 0, spurious = 0, req_prev = 0;
   int          req_len = 0, last_req_len = 0;
   int          done_log[$];   // 1 fetch, 2 load, 3 store

   // Reference model: which access owns the bus, how long it has run, and results
   int          m_phase = 0;   // 0 bus free, 1 access in flight, 2 completion cycle
   bit          m_data = 0, m_we = 0, m_err = 0;
   logic [1:0]  m_size = '0;
   logic [31:0] m_addr = '0, m_wdata = '0, m_instr = '0, m_ldata = '0;
   int          m_age = 0, m_streak = 0;

   task automatic model_reset();
      m_phase = 0; m_err = 0; m_instr = '0; m_ldata = '0; m_age = 0; m_streak = 0;
   endtask

   task automatic step();
      dreq_t r;
      bit    gd, gf;
      @(negedge CLK_CPU);
      check("bus_req", 32'(bus_req), 32'(m_phase == 1));
      if (m_phase == 1) begin
         check("bus_addr", bus_addr, m_addr);
         check("bus_we", 32'(bus_we), 32'(m_we));
         check("bus_size", 32'(bus_size), 32'(m_size));
         if (m_we) check("bus_wdata", bus_wdata, m_wdata);
      end
      check("fetch_valid", 32'(fetch_valid), 32'(m_phase == 2 && !m_data));
      check("read_data_valid", 32'(read_data_valid), 32'(m_phase == 2 && m_data && !m_we));
      check("write_ready", 32'(write_ready), 32'(m_phase == 2 && m_data && m_we));
      check("instr_fetch", instr_fetch, m_instr);
      check("mem_read_data", mem_read_data, m_ldata);
      check("timeout_err", 32'(timeout_err), 32'(m_err));
      check("starve_cnt", 32'(debug[27:24]), 32'(m_streak));

      if (fetch_valid) done_log.push_back(1);
      if (read_data_valid) done_log.push_back(2);
      if (write_ready) done_log.push_back(3);
      if (bus_req) req_len++;
      else if (req_prev) begin last_req_len = req_len; req_len = 0; end

      if (fetch_valid && fetch_enable) begin
         fetch_enable = 1'b0;
         fetch_gap = $urandom_range(0, gap_max);
      end else if (!fetch_enable) begin
         if (fetch_gap > 0) fetch_gap--;
         else if (fetch_q.size() > 0) begin
            fetch_addr = fetch_q.pop_front();
            fetch_enable = 1'b1;
         end
      end
      if ((read_data_valid || write_ready) && data_en) begin
         data_en = 1'b0;
         data_gap = $urandom_range(0, gap_max);
      end else if (!data_en) begin
         if (data_gap > 0) data_gap--;
         else if (data_q.size() > 0) begin
            r = data_q.pop_front();
            data_we = r.we; store_size = r.size; data_addr = r.addr; write_data = r.wdata;
            data_en = 1'b1;
         end
      end

      if (bus_req) begin
         if (!req_prev) begin
            ack_wait = 0;
            cur_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
            cur_hang = hang_next;
            hang_next = 0;
         end else ack_wait++;
         bus_ack = !cur_hang && (ack_wait == cur_delay);
         bus_rdata = mem_word(bus_addr);
      end else begin
         bus_ack = spurious && ($urandom_range(0, 3) == 0);
         bus_rdata = $urandom;
      end
      req_prev = bus_req;

      // Predict the effect of the coming rising edge
      case (m_phase)
         0: begin
            gd = data_en && !(fetch_enable && m_streak == STARVE_MAX);
            gf = !gd && fetch_enable;
            if (!fetch_enable) m_streak = 0;
            else if (gd) m_streak = (m_streak < STARVE_MAX) ? m_streak + 1 : m_streak;
            else m_streak = 0;
            if (gd) begin
               m_phase = 1; m_data = 1; m_we = data_we; m_addr = data_addr;
               m_size = (store_size == 2'b11) ? 2'b10 : store_size;
               m_wdata = write_data; m_age = 1;
            end else if (gf) begin
               m_phase = 1; m_data = 0; m_we = 0; m_addr = fetch_addr; m_size = 2'b10;
               m_age = 1;
            end
         end
         1: begin
            if (bus_ack) begin
               m_phase = 2;
               if (!m_data) m_instr = mem_word(m_addr);
               else if (!m_we) m_ldata = mem_word(m_addr);
            end else if (m_age == TMO) begin
               m_phase = 2; m_err = 1;
               if (!m_data) m_instr = NOP;
               else if (!m_we) m_ldata = '0;
            end else m_age++;
         end
         default: m_phase = 0;
      endcase
   endtask

   task automatic drain(input int limit);
      int cyc;
      bit quiet;
      cyc = 0;
      quiet = 0;
      while (!quiet && cyc < limit) begin
         step();
         cyc++;
         quiet = fetch_q.size() == 0 && data_q.size() == 0 && !fetch_enable && !data_en &&
                 m_phase == 0;
      end
      check("drain_quiet", 32'(quiet), 32'd1);
   endtask

   task automatic apply_reset();
      @(negedge CLK_CPU);
      resetn = 1'b0;
      fetch_enable = 1'b0; data_en = 1'b0; bus_ack = 1'b0;
      fetch_q.delete(); data_q.delete();
      fetch_gap = 0; data_gap = 0; hang_next = 0; req_prev = 0; req_len = 0;
      model_reset();
      #1;
      check("rst_bus_req", 32'(bus_req), 32'd0);
      check("rst_bus_addr", bus_addr, 32'd0);
      check("rst_done", 32'({fetch_valid, read_data_valid, write_ready}), 32'd0);
      check("rst_instr", instr_fetch, 32'd0);
      check("rst_rdata", mem_read_data, 32'd0);
      check("rst_timeout_err", 32'(timeout_err), 32'd0);
      check("rst_debug", debug, 32'd0);
      repeat (2) @(negedge CLK_CPU);
      resetn = 1'b1;
   endtask

   task automatic push_data(input bit we, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata);
      dreq_t r;
      r.we = we; r.size = size; r.addr = addr; r.wdata = wdata;
      data_q.push_back(r);
   endtask

   initial begin
      int w_before, w_total, hangs_left;
      bit seen_f;

      // 1: single fetch, ack two cycles after request
      apply_reset();
      fixed_delay = 2;
      fetch_q.push_back(32'h0000_0100);
      drain(50);
      check("t1_instr", instr_fetch, 32'h0050_0093);
      check("t1_pulses", 32'(done_log.size()), 32'd1);

      // 2: simultaneous load and fetch, data wins then fetch
      done_log.delete();
      fixed_delay = 0;
      push_data(1'b0, 2'b00, 32'h0000_2000, 32'h0);
      fetch_q.push_back(32'h0000_0104);
      drain(50);
      check("t2_first_load", 32'(done_log[0]), 32'd2);
      check("t2_then_fetch", 32'(done_log[1]), 32'd1);
      check("t2_load_data", mem_read_data, mem_word(32'h0000_2000));

      // 3: fetch held against back-to-back stores
      done_log.delete();
      fixed_delay = 1;
      fetch_q.push_back(32'h0000_0200);
      for (int i = 0; i < 5; i++)
         push_data(1'b1, 2'(i), 32'h0000_3000 + 32'(4 * i), 32'hCAFE_0000 + 32'(i));
      drain(100);
      w_before = 0; w_total = 0; seen_f = 0;
      for (int i = 0; i < done_log.size(); i++) begin
         if (done_log[i] == 1) seen_f = 1;
         if (done_log[i] == 3) begin
            w_total++;
            if (!seen_f) w_before++;
         end
      end
      check("t3_writes_before_fetch", 32'(w_before), 32'd4);
      check("t3_total_writes", 32'(w_total), 32'd5);

      // 4: hung store times out, error is sticky
      done_log.delete();
      hang_next = 1;
      push_data(1'b1, 2'b10, 32'h0000_4000, 32'h1234_ABCD);
      drain(TMO + 20);
      check("t4_req_len", 32'(last_req_len), 32'(TMO));
      check("t4_write_ready", 32'(done_log.size() == 1 && done_log[0] == 3), 32'd1);
      check("t4_timeout_err", 32'(timeout_err), 32'd1);
      fetch_q.push_back(32'h0000_0300);
      drain(50);
      check("t4_sticky", 32'(timeout_err), 32'd1);

      // ack in the very last watchdog cycle: no error
      apply_reset();
      fixed_delay = TMO - 1;
      push_data(1'b0, 2'b01, 32'h0000_5000, 32'h0);
      drain(TMO + 20);
      check("ack_at_limit_err", 32'(timeout_err), 32'd0);
      check("ack_at_limit_data", mem_read_data, mem_word(32'h0000_5000));

      // 5: fetch timeout returns NOP, then reset in the middle of an access
      fixed_delay = 0;
      hang_next = 1;
      fetch_q.push_back(32'h0000_0400);
      drain(TMO + 20);
      check("t5_nop", instr_fetch, NOP);
      hang_next = 1;
      push_data(1'b0, 2'b10, 32'h0000_6000, 32'h0);
      repeat (10) step();
      check("t5_busy_before_reset", 32'(bus_req), 32'd1);
      apply_reset();

      // Random traffic with spurious idle acks and a couple of hung accesses
      fixed_delay = -1; spurious = 1; gap_max = 3; hangs_left = 2;
      for (int c = 0; c < 3000; c++) begin
         if (fetch_q.size() == 0 && $urandom_range(0, 1) == 0)
            fetch_q.push_back($urandom & 32'hFFFF_FFFC);
         if (data_q.size() == 0 && $urandom_range(0, 1) == 0)
            push_data(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom);
         if (hangs_left > 0 && $urandom_range(0, 499) == 0) begin
            hang_next = 1;
            hangs_left--;
         end
         step();
      end
      drain(2 * TMO + 100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: time %0t reached, required finish before it", $time);
      $fatal(1);
   end

endmodule
